// File: rtl/uart_alu_if.sv
// UART-to-ALU frame bridge: receives A, B, OP bytes, drives a registered ALU, returns the result.
// Define UART_ALU_FLAGS_EN to append a {carry, zero} flags byte after each result byte.
module uart_alu_if #(
   parameter int DBIT        = 8,
   parameter int NB_OP       = 6,
   parameter int TIMEOUT_CYC = 1000000,
   parameter int TO_BITS     = 20
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             rx_empty,
   input  logic [DBIT-1:0]  r_data,
   output logic             rd_uart,
   input  logic             tx_full,
   output logic             wr_uart,
   output logic [DBIT-1:0]  w_data,
   output logic [DBIT-1:0]  alu_a,
   output logic [DBIT-1:0]  alu_b,
   output logic [NB_OP-1:0] alu_op,
   input  logic [DBIT-1:0]  alu_result,
   input  logic             alu_carry,
   input  logic             alu_zero,
   output logic             busy,
   output logic             timeout_err
);

   localparam logic [2:0] WAIT_A     = 3'd0;
   localparam logic [2:0] WAIT_B     = 3'd1;
   localparam logic [2:0] WAIT_OP    = 3'd2;
   localparam logic [2:0] EXEC       = 3'd3;
   localparam logic [2:0] SEND       = 3'd4;
`ifdef UART_ALU_FLAGS_EN
   localparam logic [2:0] SEND_FLAGS = 3'd5;
`endif

   localparam logic [TO_BITS-1:0] TO_LAST = TO_BITS'(TIMEOUT_CYC - 1);

   logic [2:0]         state;
   logic [TO_BITS-1:0] to_cnt;
   logic [DBIT-1:0]    a_sh, b_sh;
   logic               in_wait, mid_frame, in_send, to_hit;

   assign in_wait   = (state == WAIT_A) || (state == WAIT_B) || (state == WAIT_OP);
   assign mid_frame = (state == WAIT_B) || (state == WAIT_OP);
`ifdef UART_ALU_FLAGS_EN
   logic carry_q, zero_q;
   assign in_send = (state == SEND) || (state == SEND_FLAGS);
`else
   logic unused_flags;
   assign unused_flags = alu_carry ^ alu_zero;
   assign in_send = (state == SEND);
`endif

   // Gating with reset keeps FIFOs untouched while reset is held.
   assign rd_uart = !reset && in_wait && !rx_empty;
   assign wr_uart = !reset && in_send && !tx_full;
   assign busy    = (state == EXEC) || in_send;
   // rx_empty in a wait state means no read this cycle, so a read on the threshold wins.
   assign to_hit  = mid_frame && rx_empty && (to_cnt == TO_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= WAIT_A;
         to_cnt      <= '0;
         a_sh        <= '0;
         b_sh        <= '0;
         alu_a       <= '0;
         alu_b       <= '0;
         alu_op      <= '0;
         w_data      <= '0;
         timeout_err <= 1'b0;
`ifdef UART_ALU_FLAGS_EN
         carry_q     <= 1'b0;
         zero_q      <= 1'b0;
`endif
      end else begin
         timeout_err <= 1'b0;

         if (rd_uart || !mid_frame || to_hit)
            to_cnt <= '0;
         else
            to_cnt <= to_cnt + 1'b1;

         case (state)
            WAIT_A: if (!rx_empty) begin
               a_sh  <= r_data;
               state <= WAIT_B;
            end
            WAIT_B: if (!rx_empty) begin
               b_sh  <= r_data;
               state <= WAIT_OP;
            end else if (to_hit) begin
               a_sh        <= '0;
               b_sh        <= '0;
               timeout_err <= 1'b1;
               state       <= WAIT_A;
            end
            WAIT_OP: if (!rx_empty) begin
               alu_a  <= a_sh;
               alu_b  <= b_sh;
               alu_op <= r_data[NB_OP-1:0];
               state  <= EXEC;
            end else if (to_hit) begin
               a_sh        <= '0;
               b_sh        <= '0;
               timeout_err <= 1'b1;
               state       <= WAIT_A;
            end
            EXEC: begin
               w_data <= alu_result;
`ifdef UART_ALU_FLAGS_EN
               carry_q <= alu_carry;
               zero_q  <= alu_zero;
`endif
               state  <= SEND;
            end
            SEND: if (!tx_full) begin
`ifdef UART_ALU_FLAGS_EN
               w_data <= {{(DBIT-2){1'b0}}, carry_q, zero_q};
               state  <= SEND_FLAGS;
`else
               state  <= WAIT_A;
`endif
            end
`ifdef UART_ALU_FLAGS_EN
            SEND_FLAGS: if (!tx_full) state <= WAIT_A;
`endif
            default: state <= WAIT_A;
         endcase
      end
   end

endmodule
